// File: rtl/mgmt_pkg.sv
// Shared types and constants for the management bridge: FSM states and address field layout.
package mgmt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR_HI,
      ADDR_LO,
      WRITE,
      RD_WAIT,
      RD_FULL
   } mgmt_bridge_state_t;

   localparam int MGMT_RW_FLAG_BIT = 15;
   localparam int MGMT_ADDR_BITS   = 15;

endpackage

// File: rtl/mgmt_bridge.sv
// QSPI byte stream to management bus bridge: rd_en/wr_en 1 cycle after the byte, tx_valid 1 cycle after rd_valid.
// One byte of read prefetch; at most one read in flight; tx_ready with no data ready is served with UNDERRUN_FILL.
module mgmt_bridge
   import mgmt_pkg::*;
#(
   parameter bit         AUTO_INCREMENT = 1'b1,
   parameter logic [7:0] UNDERRUN_FILL  = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        qspi_start,
   input  logic        qspi_end,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        rd_en,
   output logic [15:0] rd_addr,
   input  logic        rd_valid,
   input  logic [7:0]  rd_data,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic [15:0] underrun_count
);

   localparam logic [MGMT_ADDR_BITS-1:0] ADDR_STEP =
      AUTO_INCREMENT ? MGMT_ADDR_BITS'(1) : MGMT_ADDR_BITS'(0);

   mgmt_bridge_state_t        state, state_nxt;
   logic [MGMT_ADDR_BITS-1:0] addr, addr_nxt;
   logic                      is_read, is_read_nxt;
   logic                      pending, pending_nxt;
   logic                      hold, hold_nxt;
   logic                      tx_valid_nxt;
   logic [7:0]                tx_data_nxt;
   logic                      rd_en_nxt;
   logic [15:0]               rd_addr_nxt;
   logic                      wr_en_nxt;
   logic [15:0]               wr_addr_nxt;
   logic [7:0]                wr_data_nxt;
   logic [15:0]               underrun_nxt;
   logic                      abort;
   logic                      rd_issue;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         addr           <= '0;
         is_read        <= 1'b0;
         pending        <= 1'b0;
         hold           <= 1'b0;
         tx_valid       <= 1'b0;
         tx_data        <= UNDERRUN_FILL;
         rd_en          <= 1'b0;
         rd_addr        <= '0;
         wr_en          <= 1'b0;
         wr_addr        <= '0;
         wr_data        <= '0;
         underrun_count <= '0;
      end else begin
         state          <= state_nxt;
         addr           <= addr_nxt;
         is_read        <= is_read_nxt;
         pending        <= pending_nxt;
         hold           <= hold_nxt;
         tx_valid       <= tx_valid_nxt;
         tx_data        <= tx_data_nxt;
         rd_en          <= rd_en_nxt;
         rd_addr        <= rd_addr_nxt;
         wr_en          <= wr_en_nxt;
         wr_addr        <= wr_addr_nxt;
         wr_data        <= wr_data_nxt;
         underrun_count <= underrun_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      addr_nxt     = addr;
      is_read_nxt  = is_read;
      pending_nxt  = pending;
      hold_nxt     = hold;
      tx_valid_nxt = tx_valid;
      tx_data_nxt  = tx_data;
      rd_en_nxt    = 1'b0;
      rd_addr_nxt  = rd_addr;
      wr_en_nxt    = 1'b0;
      wr_addr_nxt  = wr_addr;
      wr_data_nxt  = wr_data;
      underrun_nxt = underrun_count;
      abort        = qspi_start | qspi_end;
      rd_issue     = 1'b0;

      if (rd_valid)
         pending_nxt = 1'b0;

      // Only data-phase states count underruns; the address phase has nothing to return yet.
      if (tx_ready && (state == WRITE || state == RD_WAIT)) begin
         tx_data_nxt = UNDERRUN_FILL;
         if (underrun_count != 16'hffff)
            underrun_nxt = underrun_count + 16'd1;
      end

      case (state)
         ADDR_HI: begin
            if (rx_valid) begin
               addr_nxt[MGMT_ADDR_BITS-1:8] = rx_data[6:0];
               is_read_nxt                  = rx_data[MGMT_RW_FLAG_BIT-8];
               hold_nxt                     = 1'b0;
               state_nxt                    = ADDR_LO;
            end
         end
         ADDR_LO: begin
            if (!hold && rx_valid) begin
               addr_nxt[7:0] = rx_data;
               if (!is_read)
                  state_nxt = WRITE;
               else if (pending)
                  hold_nxt = 1'b1;
               else if (!abort)
                  rd_issue = 1'b1;
            end else if (hold && !pending && !abort) begin
               rd_issue = 1'b1;
            end
         end
         WRITE: begin
            if (rx_valid) begin
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = {1'b0, addr};
               wr_data_nxt = rx_data;
               addr_nxt    = addr + ADDR_STEP;
            end
         end
         RD_WAIT: begin
            if (rd_valid && pending && !abort) begin
               tx_data_nxt  = rd_data;
               tx_valid_nxt = 1'b1;
               state_nxt    = RD_FULL;
            end
         end
         RD_FULL: begin
            if (tx_ready && !abort) begin
               tx_valid_nxt = 1'b0;
               tx_data_nxt  = UNDERRUN_FILL;
               addr_nxt     = addr + ADDR_STEP;
               rd_issue     = 1'b1;
            end
         end
         default: ;
      endcase

      // rd_addr only moves here, so it stays put for the whole time the read is outstanding.
      if (rd_issue) begin
         rd_en_nxt   = 1'b1;
         rd_addr_nxt = {1'b0, addr_nxt};
         pending_nxt = 1'b1;
         hold_nxt    = 1'b0;
         state_nxt   = RD_WAIT;
      end

      if (abort) begin
         tx_valid_nxt = 1'b0;
         tx_data_nxt  = UNDERRUN_FILL;
         hold_nxt     = 1'b0;
         state_nxt    = qspi_start ? ADDR_HI : IDLE;
      end
   end

endmodule
